// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, with single-cycle results for divide-by-zero and signed overflow.
module div_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic             op_rem_q;

    // Ripple unsigned less-than, LSB to MSB: a higher differing bit overrides lower ones.
    function automatic logic lt_u(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic lt;
        lt = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            lt = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & lt);
        end
        return lt;
    endfunction

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    logic signed [WIDTH-1:0] dividend_s;
    logic signed [WIDTH-1:0] divisor_s;
    logic                    dvd_neg;
    logic                    dvs_neg;
    logic [WIDTH-1:0]        dvd_mag;
    logic [WIDTH-1:0]        dvs_mag;
    logic                    div_zero;
    logic                    sgn_ovf;

    assign dividend_s = dividend;
    assign divisor_s  = divisor;
    assign dvd_neg    = op_signed && (dividend_s < 0);
    assign dvs_neg    = op_signed && (divisor_s < 0);
    assign dvd_mag    = dvd_neg ? neg2c(dividend) : dividend;
    assign dvs_mag    = dvs_neg ? neg2c(divisor) : divisor;
    assign div_zero   = (divisor == '0);
    assign sgn_ovf    = op_signed && (dividend == MIN_NEG) && (divisor == '1);

    // The dividend magnitude shifts out of quo's MSB while quotient bits shift in at its LSB.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    assign rem_shift = {rem, quo[WIDTH-1]};
    assign ge        = ~lt_u(rem_shift, {1'b0, dvs});
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            cnt          <= '0;
            quo          <= '0;
            dvs          <= '0;
            rem          <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            op_rem_q     <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        op_rem_q <= op_rem;
                        q_neg    <= dvd_neg ^ dvs_neg;
                        r_neg    <= dvd_neg;
                        quo      <= dvd_mag;
                        dvs      <= dvs_mag;
                        rem      <= '0;
                        busy     <= 1'b1;
                        if (div_zero) begin
                            result       <= op_rem ? dividend : '1;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else if (sgn_ovf) begin
                            result       <= op_rem ? '0 : dividend;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cnt   <= CNT_W'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo <= {quo[WIDTH-2:0], ge};
                    rem <= ge ? rem_sub : rem_shift[WIDTH-1:0];
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_rem_q) begin
                        result <= r_neg ? neg2c(rem) : rem;
                    end else begin
                        result <= q_neg ? neg2c(quo) : quo;
                    end
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized operations
// checked against plain SystemVerilog division.
module tb_div_unit;

    localparam int WIDTH = 64;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             op_signed;
    logic             op_rem;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_signed    (op_signed),
        .op_rem       (op_rem),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [63:0] last_exp = '0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic s, input logic [63:0] a, input logic [63:0] b);
        return (b == 64'd0) || (s && a == MIN_NEG && b == '1);
    endfunction

    // Reference: language-level truncating division, corner cases from the rules.
    function automatic logic [63:0] ref_div(input logic s, input logic r,
                                            input logic [63:0] a, input logic [63:0] b);
        longint sa, sb_;
        if (b == 64'd0) return r ? a : '1;
        if (s && a == MIN_NEG && b == '1) return r ? 64'd0 : a;
        if (s) begin
            sa  = a;
            sb_ = b;
            return r ? 64'(sa % sb_) : 64'(sa / sb_);
        end
        return r ? (a % b) : (a / b);
    endfunction

    always @(negedge clk) begin
        if (!reset && result_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_valid: got result_valid=1 want 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check64("result", result, mon_e.res);
                check64("valid_cycle", 64'(cyc), 64'(mon_e.at));
                last_exp = mon_e.res;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 want 0 (cycle %0d)", cyc);
        end
    endtask

    task automatic issue(input logic s, input logic r, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        wait_idle();
        op_signed = s;
        op_rem    = r;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        e.res = ref_div(s, r, a, b);
        e.at  = cyc + (is_special(s, a, b) ? 1 : WIDTH + 2);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit          ok;
        logic [63:0] a, b;
        logic        s, r;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op_signed = 1'b0; op_rem = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_valid", 64'(result_valid), 64'd0);
        check64("reset_result", result, 64'd0);

        // DIVU 100/7 with busy window over the whole operation.
        issue(1'b0, 1'b0, 64'd100, 64'd7);
        ok = 1'b1;
        for (int i = 0; i < 65; i++) begin
            if (!busy) ok = 1'b0;
            if (i < 64) @(negedge clk);
        end
        check64("busy_window", 64'(ok), 64'd1);

        issue(1'b1, 1'b1, -64'sd7, 64'd2);
        issue(1'b1, 1'b0, -64'sd7, 64'd2);
        issue(1'b0, 1'b0, 64'h1234, 64'd0);
        issue(1'b0, 1'b1, 64'h1234, 64'd0);
        issue(1'b1, 1'b0, -64'sd5, 64'd0);
        issue(1'b1, 1'b0, MIN_NEG, '1);
        issue(1'b1, 1'b1, MIN_NEG, '1);
        issue(1'b0, 1'b0, MIN_NEG, '1);
        issue(1'b1, 1'b1, 64'd45, -64'sd7);

        // Start pulses during a running operation must be ignored.
        issue(1'b0, 1'b0, 64'd1000, 64'd9);
        repeat (4) @(negedge clk);
        op_signed = 1'b1; op_rem = 1'b1; dividend = 64'd77777; divisor = 64'd3; start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Flush in CALC cycle 30, then a fresh operation.
        issue(1'b0, 1'b0, 64'd123456789, 64'd5);
        repeat (29) @(negedge clk);
        flush = 1'b1;
        sb.delete();
        @(negedge clk);
        flush = 1'b0;
        check64("flush_busy", 64'(busy), 64'd0);
        check64("flush_result_kept", result, last_exp);
        issue(1'b0, 1'b0, '1, '1);
        wait_idle();

        // Flush wins over start in the same cycle.
        @(negedge clk);
        dividend = 64'd50; divisor = 64'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check64("flush_over_start_busy", 64'(busy), 64'd0);
        check64("flush_over_start_valid", 64'(result_valid), 64'd0);

        // Reset in CALC cycle 10 discards the operation.
        issue(1'b1, 1'b0, 64'd987654321, 64'd13);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        last_exp = '0;
        check64("midreset_busy", 64'(busy), 64'd0);
        check64("midreset_result", result, 64'd0);
        check64("midreset_valid", 64'(result_valid), 64'd0);
        issue(1'b0, 1'b1, 64'd1000, 64'd7);

        for (int k = 0; k < 24; k++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'($urandom_range(1, 20));
                1:       b = {$urandom, $urandom};
                2:       b = a >> $urandom_range(1, 63);
                default: b = $urandom_range(0, 1) ? 64'd0 : '1;
            endcase
            if ($urandom_range(0, 3) == 0) b = -b;
            issue(s, r, a, b);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check64("drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation, sampled only in IDLE.
REQ-005 SHALL have port op_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
REQ-006 SHALL have port op_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-007 SHALL have port dividend  input  WIDTH  numerator, sampled with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator, sampled with start.
REQ-009 SHALL have port flush  input  1  pipeline kill, aborts any in-flight operation.
REQ-010 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-011 SHALL have port result_valid  output  1  one-cycle pulse, result is ready.
REQ-012 SHALL have port result  output  WIDTH  quotient or remainder per op_rem.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE with start=1 and flush=0, latch all operands and op bits, and go to CALC, or go to DONE for the special cases.
REQ-015 SHALL ignore start in every state other than IDLE; operands latched at acceptance SHALL NOT change mid-operation.
REQ-016 SHALL, in signed mode, convert operands to magnitudes at acceptance, and record the quotient sign as the XOR of the operand signs and the remainder sign as the dividend sign.
REQ-017 SHALL run CALC as restoring division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, counted by a log2(WIDTH)+1-bit counter.
REQ-018 SHALL, each CALC step, shift the partial remainder left by 1 and shift in the next dividend bit.
REQ-019 SHALL make each CALC step's restore decision as ge = NOT(partial_rem <u divisor_mag) using the team's gate-level unsigned less-than comparator.
REQ-020 SHALL, when ge=1, subtract divisor_mag from the partial remainder and set the quotient bit to 1; otherwise it SHALL set the quotient bit to 0.
REQ-021 SHALL, in FIX (1 cycle), apply the recorded signs by two's-complement negation and select quotient or remainder into result; then go to DONE.
REQ-022 SHALL, in DONE, assert result_valid for exactly one cycle and then return to IDLE.
REQ-023 SHALL keep result stable from DONE until the next accepted start.
REQ-024 SHALL give a normal-path latency where start is accepted at edge T, CALC covers cycles T+1..T+WIDTH, FIX is cycle T+WIDTH+1, and result_valid is high in cycle T+WIDTH+2 (cycle 66 for WIDTH=64).
REQ-025 SHALL treat divisor=0 as a special case: quotient = all ones, remainder = dividend unmodified (both modes), and result_valid high in cycle T+1.
REQ-026 SHALL treat signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor = all ones, op_signed=1) as a special case: quotient = dividend, remainder = 0, and result_valid high in cycle T+1.
REQ-027 SHALL, on flush=1 in any state, go to IDLE on the next edge, suppress result_valid and leave result unchanged; flush has priority over start in the same cycle.
REQ-028 SHALL give a back-to-back start in the cycle after DONE (state back in IDLE) its normal latency.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, force state=IDLE, busy=0, result_valid=0, result=0, counter=0, and clear all internal operand and remainder registers.
REQ-030 SHALL have reset take priority over flush and start, including a mid-CALC reset, which SHALL discard the operation with no result_valid.

Verification
REQ-031 SHALL verify: DIVU 100/7, op_rem=0 -> result=14, result_valid exactly in cycle T+66, busy high in T+1..T+65.
REQ-032 SHALL verify: REM signed -7/2 -> result = -1 (all ones); DIV signed -7/2 -> result = -3.
REQ-033 SHALL verify: divisor=0, dividend=0x1234 -> DIVU result=0xFFFF_FFFF_FFFF_FFFF, REMU result=0x1234, both in cycle T+1.
REQ-034 SHALL verify: DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> result=0x8000_0000_0000_0000; REM -> 0.
REQ-035 SHALL verify: flush asserted in CALC cycle 30 -> IDLE next cycle, no result_valid, and a new start one cycle later completes correctly (0xFFFF_FFFF_FFFF_FFFF / 0xFFFF_FFFF_FFFF_FFFF -> 1).
REQ-036 SHALL verify: reset in CALC cycle 10 -> busy=0, result=0 next cycle; start asserted during busy -> ignored, first result unaffected.
